pipe_hazard_seq: RTL and testbench
==================================

Name: pipe_hazard_seq

Overview:
- Central stall/flush sequencer for the 8-bit five-stage pipeline.
- Drives the stall and flush controls of the IF/ID and ID/EX pipeline registers.
- Resolves load-use hazards, taken branches, RET bubbling and interrupt entry.
- Sits beside the decode stage; its outputs are consumed by the PC register, the IF/ID register and the ID/EX register (flush_E).

Parameters:
- RET_BUBBLES, 2, number of bubble cycles inserted after RET reaches EX, before the PC reloads from memory (legal 1..7).
- REG_AW, 2, register address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- RA_D  in  REG_AW  source reg A of the instruction in decode
- RB_D  in  REG_AW  source reg B of the instruction in decode
- use_ra_D  in  1  decode instruction reads RA
- use_rb_D  in  1  decode instruction reads RB
- rd_en_E  in  1  instruction in EX is a memory load
- dst_E  in  REG_AW  destination reg of the instruction in EX
- wr_en_regf_E  in  1  EX instruction writes the register file
- branch_taken_E  in  1  branch/jump/call resolved taken in EX
- is_ret_E  in  1  RET/RTI in EX
- intr  in  1  external interrupt request, level or pulse
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID
- flush_D  out  1  clear IF/ID
- flush_E  out  1  clear ID/EX
- pc_load_ret  out  1  one-cycle pulse: PC loads the return address from the data memory readback
- int_inject  out  1  one-cycle pulse: decode substitutes the interrupt push sequence (push PC, f_save)
- busy  out  1  FSM not in RUN

Behaviour:
- State: RUN, RET_WAIT, INT_DRAIN, INT_PUSH.
- Internal: 3-bit counter cnt, pending flag int_pend.
- On reset: state=RUN, cnt=0, int_pend=0, pc_load_ret=0, int_inject=0, busy=0.
- While reset is high: stall_F=stall_D=0, flush_D=flush_E=1.
- Register hold/flush outputs are combinational from state and inputs. pc_load_ret, int_inject and busy are registered.
- int_pend is set on any cycle with intr=1. It is cleared when INT_PUSH is entered. A set and a clear in the same cycle leave it set.
- load_use = rd_en_E & wr_en_regf_E & ((use_ra_D & RA_D==dst_E) | (use_rb_D & RB_D==dst_E)).

RUN (priority, highest first):
1. branch_taken_E: flush_D=1, flush_E=1, no stall. Stay in RUN. Interrupt entry is deferred this cycle.
2. is_ret_E: flush_D=1, flush_E=1. Go to RET_WAIT with cnt=RET_BUBBLES-1.
3. load_use: stall_F=1, stall_D=1, flush_E=1. Exactly one bubble per hazard (on the next cycle the load has left EX).
4. int_pend: stall_F=1, flush_D=1. Go to INT_DRAIN.
5. Otherwise all controls are 0.

RET_WAIT:
- stall_F=1, flush_D=1, flush_E=0.
- If cnt!=0, decrement cnt.
- If cnt==0, return to RUN and assert pc_load_ret for the next cycle only.
- Branch and load_use inputs are ignored in this state. int_pend stays latched.

INT_DRAIN:
- Lasts one cycle: stall_F=1, flush_D=1. Go to INT_PUSH.

INT_PUSH:
- Lasts one cycle: stall_F=1, stall_D=1.
- int_inject=1 on the cycle after entry; int_pend cleared. Return to RUN.
- A RET arriving in EX while in INT_* is handled in RUN afterwards; RET cannot reach EX in those states because D is flushed.

Other rules:
- Simultaneous stall and flush on the same register: flush wins at the register. This block never asserts stall_D together with flush_D.
- busy=1 in every non-RUN state, registered with the state.
- Asserting reset mid-sequence returns to RUN in one cycle. Pending interrupts and in-flight RET counts are lost.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on every cycle with stall_F=1.
  - flush_cnt increments on every cycle with flush_E=1 or flush_D=1.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and registers do not exist and the behaviour is otherwise identical.

Test Plan:
- Load-use: rd_en_E=1, wr_en_regf_E=1, dst_E=2, RA_D=2, use_ra_D=1 for one cycle -> stall_F=stall_D=flush_E=1 for exactly 1 cycle, then all 0.
- Branch with hazard: branch_taken_E=1 together with a load_use match -> flush_D=flush_E=1, stall_F=0, state stays RUN.
- RET with RET_BUBBLES=2: is_ret_E pulse at cycle N -> flush_D=flush_E=1 at N; stall_F=flush_D=1 at N+1 and N+2; pc_load_ret=1 at N+3 only; busy=1 at N+1..N+2.
- Interrupt: 1-cycle intr pulse while idle -> N+1: stall_F=flush_D=1 (INT_DRAIN at N+2); int_inject=1 exactly once at N+4; busy returns to 0 afterwards.
- Interrupt during RET_WAIT: intr pulse mid-RET -> RET completes with pc_load_ret first; interrupt entry follows immediately; int_inject pulses once.
- Reset mid-RET_WAIT: reset=1 for 1 cycle -> flush_D=flush_E=1 during reset; busy=0, no pc_load_ret afterwards. With HAZ_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/pipe_hazard_seq_if.sv
// Hazard sequencer bundle: decode/EX hazard inputs and pipeline controls.
// HAZ_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface pipe_hazard_seq_if #(
    parameter int REG_AW = 2
);
    logic [REG_AW-1:0] RA_D;
    logic [REG_AW-1:0] RB_D;
    logic              use_ra_D;
    logic              use_rb_D;
    logic              rd_en_E;
    logic [REG_AW-1:0] dst_E;
    logic              wr_en_regf_E;
    logic              branch_taken_E;
    logic              is_ret_E;
    logic              intr;
    logic              stall_F;
    logic              stall_D;
    logic              flush_D;
    logic              flush_E;
    logic              pc_load_ret;
    logic              int_inject;
    logic              busy;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    modport master (
        output RA_D, RB_D, use_ra_D, use_rb_D,
        output rd_en_E, dst_E, wr_en_regf_E,
        output branch_taken_E, is_ret_E, intr,
        input  stall_F, stall_D, flush_D, flush_E,
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt, flush_cnt,
`endif
        input  pc_load_ret, int_inject, busy
    );

    modport slave (
        input  RA_D, RB_D, use_ra_D, use_rb_D,
        input  rd_en_E, dst_E, wr_en_regf_E,
        input  branch_taken_E, is_ret_E, intr,
        output stall_F, stall_D, flush_D, flush_E,
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt, flush_cnt,
`endif
        output pc_load_ret, int_inject, busy
    );
endinterface

// File: rtl/pipe_hazard_seq.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch,
// RET bubbling and interrupt entry. HAZ_PERF_CNT_EN adds perf counters.
module pipe_hazard_seq #(
    parameter int RET_BUBBLES = 2,
    parameter int REG_AW      = 2
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN, RET_WAIT, INT_DRAIN, INT_PUSH
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic       int_pend;
    logic       pc_load_ret;
    logic       int_inject;
    logic       busy;
    logic       load_use;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;

    assign load_use = bus.rd_en_E & bus.wr_en_regf_E &
                      ((bus.use_ra_D & (bus.RA_D == bus.dst_E)) |
                       (bus.use_rb_D & (bus.RB_D == bus.dst_E)));

    // State, bubble counter, pending interrupt and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= 3'd0;
            int_pend    <= 1'b0;
            pc_load_ret <= 1'b0;
            int_inject  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            // A new request in the cycle INT_PUSH is entered stays pending.
            int_pend    <= (int_pend & (state != INT_DRAIN)) | bus.intr;
            pc_load_ret <= (state == RET_WAIT) && (cnt == 3'd0);
            int_inject  <= (state == INT_PUSH);
            busy        <= (state_nx != RUN);
        end
    end

    // Next-state and bubble count selection.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RUN: begin
                if (bus.branch_taken_E) begin
                    state_nx = RUN;
                end else if (bus.is_ret_E) begin
                    state_nx = RET_WAIT;
                    cnt_nx   = 3'(RET_BUBBLES - 1);
                end else if (load_use) begin
                    state_nx = RUN;
                end else if (int_pend) begin
                    state_nx = INT_DRAIN;
                end
            end
            RET_WAIT: begin
                if (cnt != 3'd0) cnt_nx = cnt - 3'd1;
                else             state_nx = RUN;
            end
            INT_DRAIN: state_nx = INT_PUSH;
            INT_PUSH:  state_nx = RUN;
            default:   state_nx = RUN;
        endcase
    end

    // Pipeline register hold/flush controls.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (bus.branch_taken_E || bus.is_ret_E) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (int_pend) begin
                        stall_f = 1'b1;
                        flush_d = 1'b1;
                    end
                end
                RET_WAIT, INT_DRAIN: begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
                INT_PUSH: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                end
                default: begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end
            endcase
        end
    end

    assign bus.stall_F     = stall_f;
    assign bus.stall_D     = stall_d;
    assign bus.flush_D     = flush_d;
    assign bus.flush_E     = flush_e;
    assign bus.pc_load_ret = pc_load_ret;
    assign bus.int_inject  = int_inject;
    assign bus.busy        = busy;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    // Saturating stall/flush cycle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_f && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if ((flush_d || flush_e) && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Bench for pipe_hazard_seq: table of RUN-state hazard vectors plus
// hand sequences for RET, interrupt and reset corners.
module tb_pipe_hazard_seq;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_seq_if #(.REG_AW(2)) bus ();

    pipe_hazard_seq #(.RET_BUBBLES(2), .REG_AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected word: {stall_F, stall_D, flush_D, flush_E,
    //                 pc_load_ret, int_inject, busy}
    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_t;

    typedef struct {
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] dst;
        logic       ua;
        logic       ub;
        logic       rd;
        logic       wr;
        logic       br;
        logic [3:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [6:0] actual();
        return {bus.stall_F, bus.stall_D, bus.flush_D, bus.flush_E,
                bus.pc_load_ret, bus.int_inject, bus.busy};
    endfunction

    task automatic idle();
        bus.RA_D           = 2'd0;
        bus.RB_D           = 2'd0;
        bus.dst_E          = 2'd0;
        bus.use_ra_D       = 1'b0;
        bus.use_rb_D       = 1'b0;
        bus.rd_en_E        = 1'b0;
        bus.wr_en_regf_E   = 1'b0;
        bus.branch_taken_E = 1'b0;
        bus.is_ret_E       = 1'b0;
        bus.intr           = 1'b0;
    endtask

    // Push expectation, compare at the falling edge, advance one cycle.
    task automatic step(input string nm, input logic [6:0] e);
        sb_t s;
        sb.push_back('{nm, e});
        @(negedge clk);
        s = sb.pop_front();
        n_vec++;
        if (actual() !== s.exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", s.name, actual(), s.exp);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk_cnt(input string nm, input logic [15:0] got,
                           input logic [15:0] e);
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, e);
        end
    endtask

    initial begin
        tbl[0] = '{2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[1] = '{2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1101};
        tbl[2] = '{2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[3] = '{2'd1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101};
        tbl[4] = '{2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[5] = '{2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[6] = '{2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[7] = '{2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[8] = '{2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011};
        tbl[9] = '{2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011};

        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("reset_hold", 7'b0011000);
        reset = 1'b0;
        step("after_reset", 7'b0000000);

        for (int i = 0; i < 10; i++) begin
            bus.RA_D           = tbl[i].ra;
            bus.RB_D           = tbl[i].rb;
            bus.dst_E          = tbl[i].dst;
            bus.use_ra_D       = tbl[i].ua;
            bus.use_rb_D       = tbl[i].ub;
            bus.rd_en_E        = tbl[i].rd;
            bus.wr_en_regf_E   = tbl[i].wr;
            bus.branch_taken_E = tbl[i].br;
            step($sformatf("vec%0d", i), {tbl[i].exp, 3'b000});
        end
        step("post_vec_idle", 7'b0000000);

        // RET with two bubbles; hazard inputs ignored while waiting.
        bus.is_ret_E = 1'b1;
        step("ret_n", 7'b0011000);
        bus.branch_taken_E = 1'b1;
        bus.rd_en_E = 1'b1;
        bus.wr_en_regf_E = 1'b1;
        bus.use_ra_D = 1'b1;
        step("ret_n1", 7'b1010001);
        step("ret_n2", 7'b1010001);
        step("ret_n3", 7'b0000100);
        step("ret_n4", 7'b0000000);

        // Interrupt pulse while idle.
        bus.intr = 1'b1;
        step("int_n", 7'b0000000);
        step("int_n1", 7'b1010000);
        step("int_n2", 7'b1010001);
        step("int_n3", 7'b1100001);
        step("int_n4", 7'b0000010);
        step("int_n5", 7'b0000000);

        // Interrupt arriving during RET_WAIT.
        bus.is_ret_E = 1'b1;
        step("rint_n", 7'b0011000);
        bus.intr = 1'b1;
        step("rint_n1", 7'b1010001);
        step("rint_n2", 7'b1010001);
        step("rint_n3", 7'b1010100);
        step("rint_n4", 7'b1010001);
        step("rint_n5", 7'b1100001);
        step("rint_n6", 7'b0000010);
        step("rint_n7", 7'b0000000);

        // Taken branch defers interrupt entry by a cycle.
        bus.intr = 1'b1;
        step("bint_n", 7'b0000000);
        bus.branch_taken_E = 1'b1;
        step("bint_n1", 7'b0011000);
        step("bint_n2", 7'b1010000);
        step("bint_n3", 7'b1010001);
        step("bint_n4", 7'b1100001);
        step("bint_n5", 7'b0000010);

        // Reset in the middle of RET_WAIT.
        bus.is_ret_E = 1'b1;
        step("rrst_n", 7'b0011000);
        step("rrst_n1", 7'b1010001);
        reset = 1'b1;
        step("rrst_n2", 7'b0011001);
        reset = 1'b0;
`ifdef HAZ_PERF_CNT_EN
        chk_cnt("stall_cnt_rst", bus.stall_cnt, 16'd0);
        chk_cnt("flush_cnt_rst", bus.flush_cnt, 16'd0);
`endif
        step("rrst_n3", 7'b0000000);
        step("rrst_n4", 7'b0000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
